// File: rtl/axi_lite_mgr_arb_if.sv
// Requester-side and manager-side bus bundle for axi_lite_mgr_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface axi_lite_mgr_arb_if #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned AXI_DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]                req_valid_i;
   logic [NUM_REQ-1:0]                req_we_i;
   logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_wdata_i;
   logic [NUM_REQ-1:0]                req_ready_o;
   logic [NUM_REQ-1:0]                wr_done_o;
   logic [NUM_REQ-1:0]                rd_done_o;
   logic [AXI_DATA_WIDTH-1:0]         rd_data_o;
   logic [1:0]                        mgr_req_o;
   logic [AXI_ADDR_WIDTH-1:0]         mgr_wr_addr_o;
   logic [AXI_ADDR_WIDTH-1:0]         mgr_rd_addr_o;
   logic [AXI_DATA_WIDTH-1:0]         mgr_wdata_o;
   logic [1:0]                        mgr_rsp_i;
   logic [AXI_DATA_WIDTH-1:0]         mgr_rd_data_i;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mgr_rsp_i, mgr_rd_data_i,
      output req_ready_o, wr_done_o, rd_done_o, rd_data_o,
             mgr_req_o, mgr_wr_addr_o, mgr_rd_addr_o, mgr_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mgr_rsp_i, mgr_rd_data_i,
      input  req_ready_o, wr_done_o, rd_done_o, rd_data_o,
             mgr_req_o, mgr_wr_addr_o, mgr_rd_addr_o, mgr_wdata_o
   );
endinterface

// File: rtl/axi_lite_mgr_arb.sv
// axi_lite_mgr_arb: shares one non-pipelined AXI-Lite manager between NUM_REQ
// requesters. Separate round-robin write and read channels, each with at most
// one operation outstanding at the manager.
module axi_lite_mgr_arb #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned AXI_DATA_WIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   axi_lite_mgr_arb_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT}         wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DATA} rd_state_e;

   // First candidate at or after ptr, wrapping; returns {hit, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                              input logic [IDX_W-1:0]   ptr);
      logic             hit;
      logic [IDX_W-1:0] sel;
      int unsigned      idx;
      hit = 1'b0;
      sel = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!hit && cand[idx]) begin
            hit = 1'b1;
            sel = IDX_W'(idx);
         end
      end
      return {hit, sel};
   endfunction

   // Pointer moves one past the winner, modulo NUM_REQ.
   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
      return (32'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
   endfunction

   logic [AXI_ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [AXI_DATA_WIDTH-1:0] wdata_a [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i]  = bus.req_addr_i [i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      assign wdata_a[i] = bus.req_wdata_i[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   end

   // Candidates are suppressed during reset so no accept pulse can escape.
   logic [NUM_REQ-1:0] wr_cand, rd_cand;
   assign wr_cand = rstn_i ? (bus.req_valid_i &  bus.req_we_i) : '0;
   assign rd_cand = rstn_i ? (bus.req_valid_i & ~bus.req_we_i) : '0;

   // ---------------- write channel ----------------
   wr_state_e                 w_state_q, w_state_d;
   logic [IDX_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
   logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NUM_REQ-1:0]        wr_done_q, wr_done_d;
   logic [NUM_REQ-1:0]        wr_gnt;
   logic                      wr_req;
   logic                      wr_hit;
   logic [IDX_W-1:0]          wr_sel;

   // Write FSM state and latched transfer registers.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         w_state_q <= W_IDLE;
         wr_ptr_q  <= '0;
         wr_idx_q  <= '0;
         wr_addr_q <= '0;
         wdata_q   <= '0;
         wr_done_q <= '0;
      end else begin
         w_state_q <= w_state_d;
         wr_ptr_q  <= wr_ptr_d;
         wr_idx_q  <= wr_idx_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         wr_done_q <= wr_done_d;
      end
   end

   // Write next-state: grant in idle, one-cycle issue, wait for manager response.
   always_comb begin
      w_state_d = w_state_q;
      wr_ptr_d  = wr_ptr_q;
      wr_idx_d  = wr_idx_q;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      wr_done_d = '0;
      wr_gnt    = '0;
      wr_req    = 1'b0;
      {wr_hit, wr_sel} = rr_pick(wr_cand, wr_ptr_q);
      case (w_state_q)
         W_IDLE: begin
            if (wr_hit) begin
               wr_gnt[wr_sel] = 1'b1;
               wr_idx_d       = wr_sel;
               wr_addr_d      = addr_a[wr_sel];
               wdata_d        = wdata_a[wr_sel];
               wr_ptr_d       = ptr_after(wr_sel);
               w_state_d      = W_ISSUE;
            end
         end
         W_ISSUE: begin
            wr_req    = 1'b1;
            w_state_d = W_WAIT;
         end
         W_WAIT: begin
            if (bus.mgr_rsp_i[0]) begin
               wr_done_d[wr_idx_q] = 1'b1;
               w_state_d           = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // ---------------- read channel ----------------
   rd_state_e                 r_state_q, r_state_d;
   logic [IDX_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
   logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [NUM_REQ-1:0]        rd_done_q, rd_done_d;
   logic [NUM_REQ-1:0]        rd_gnt;
   logic                      rd_req;
   logic                      rd_hit;
   logic [IDX_W-1:0]          rd_sel;

   // Read FSM state and latched transfer registers.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state_q <= R_IDLE;
         rd_ptr_q  <= '0;
         rd_idx_q  <= '0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
         rd_done_q <= '0;
      end else begin
         r_state_q <= r_state_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_idx_q  <= rd_idx_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         rd_done_q <= rd_done_d;
      end
   end

   // Read next-state: manager data arrives the cycle after its response,
   // so an extra DATA state captures it before completion is signalled.
   always_comb begin
      r_state_d = r_state_q;
      rd_ptr_d  = rd_ptr_q;
      rd_idx_d  = rd_idx_q;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      rd_done_d = '0;
      rd_gnt    = '0;
      rd_req    = 1'b0;
      {rd_hit, rd_sel} = rr_pick(rd_cand, rd_ptr_q);
      case (r_state_q)
         R_IDLE: begin
            if (rd_hit) begin
               rd_gnt[rd_sel] = 1'b1;
               rd_idx_d       = rd_sel;
               rd_addr_d      = addr_a[rd_sel];
               rd_ptr_d       = ptr_after(rd_sel);
               r_state_d      = R_ISSUE;
            end
         end
         R_ISSUE: begin
            rd_req    = 1'b1;
            r_state_d = R_WAIT;
         end
         R_WAIT: begin
            if (bus.mgr_rsp_i[1]) r_state_d = R_DATA;
         end
         R_DATA: begin
            rd_data_d           = bus.mgr_rd_data_i;
            rd_done_d[rd_idx_q] = 1'b1;
            r_state_d           = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write and read candidates are disjoint, so the OR stays one-hot per channel.
   assign bus.req_ready_o   = wr_gnt | rd_gnt;
   assign bus.mgr_req_o     = {rd_req, wr_req};
   assign bus.mgr_wr_addr_o = wr_addr_q;
   assign bus.mgr_rd_addr_o = rd_addr_q;
   assign bus.mgr_wdata_o   = wdata_q;
   assign bus.wr_done_o     = wr_done_q;
   assign bus.rd_done_o     = rd_done_q;
   assign bus.rd_data_o     = rd_data_q;

endmodule

// File: tb/tb_axi_lite_mgr_arb.sv
// Self-checking bench for axi_lite_mgr_arb: transaction-timing reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized requesters and manager.
module tb_axi_lite_mgr_arb;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   axi_lite_mgr_arb_if #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

   axi_lite_mgr_arb #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;
   int ncyc     = 0;

   // stimulus for the next cycle
   logic [N-1:0]  s_valid, s_we;
   logic [AW-1:0] s_addr  [N];
   logic [DW-1:0] s_wdata [N];
   logic [1:0]    s_rsp;
   logic [DW-1:0] s_rdata;
   logic          s_rstn;

   // sampled DUT outputs
   logic [N-1:0]  act_ready, act_wdone, act_rdone;
   logic [1:0]    act_req;
   logic [DW-1:0] act_rdata, act_wdata;
   logic [AW-1:0] act_waddr, act_raddr;

   // reference model: channel 0 = write, 1 = read
   int            ptr [2];
   bit            busy [2];
   int            owner [2];
   int            gcyc [2];
   int            rspc [2];
   int            m_gnt [2];
   int            m_done [2];
   logic [AW-1:0] e_waddr, e_raddr;
   logic [DW-1:0] e_wdata, e_rdata, cap;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, ncyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < 2; c++) begin
         ptr[c] = 0; busy[c] = 0; owner[c] = 0; gcyc[c] = 0; rspc[c] = -1;
      end
      e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0; cap = '0;
   endfunction

   function automatic bit in_wait(input int c);
      return busy[c] && rspc[c] < 0 && ncyc >= gcyc[c] + 2;
   endfunction

   // Expected outputs of cycle ncyc from transaction timing, then advance.
   task automatic model_cycle();
      logic [N-1:0] e_ready, e_wdone, e_rdone;
      logic [1:0]   e_req;
      logic         want;
      int           n, i;
      n = ncyc;
      e_ready = '0; e_wdone = '0; e_rdone = '0; e_req = '0;
      for (int c = 0; c < 2; c++) begin
         m_gnt[c]  = -1;
         m_done[c] = -1;
         // write done 1 cycle after response, read done 2 cycles after
         if (busy[c] && rspc[c] >= 0 && n == rspc[c] + c + 1) begin
            if (c == 0) e_wdone[owner[c]] = 1'b1;
            else begin
               e_rdone[owner[c]] = 1'b1;
               e_rdata = cap;
            end
            m_done[c] = owner[c];
            busy[c]   = 0;
         end
         e_req[c] = busy[c] && (n == gcyc[c] + 1);
      end
      if (s_rstn) begin
         for (int c = 0; c < 2; c++) begin
            want = (c == 0);
            if (!busy[c]) begin
               for (int k = 0; k < N; k++) begin
                  i = (ptr[c] + k) % N;
                  if (s_valid[i] && (s_we[i] == want)) begin
                     m_gnt[c] = i;
                     break;
                  end
               end
            end
            if (m_gnt[c] >= 0) e_ready[m_gnt[c]] = 1'b1;
         end
      end
      chk("ready",   64'(act_ready), 64'(e_ready));
      chk("mgr_req", 64'(act_req),   64'(e_req));
      chk("wr_done", 64'(act_wdone), 64'(e_wdone));
      chk("rd_done", 64'(act_rdone), 64'(e_rdone));
      chk("rd_data", 64'(act_rdata), 64'(e_rdata));
      chk("wr_addr", 64'(act_waddr), 64'(e_waddr));
      chk("rd_addr", 64'(act_raddr), 64'(e_raddr));
      chk("wdata",   64'(act_wdata), 64'(e_wdata));
      for (int c = 0; c < 2; c++) begin
         if (m_gnt[c] >= 0) begin
            busy[c]  = 1;
            owner[c] = m_gnt[c];
            gcyc[c]  = n;
            rspc[c]  = -1;
            ptr[c]   = (m_gnt[c] + 1) % N;
            if (c == 0) begin
               e_waddr = s_addr[m_gnt[c]];
               e_wdata = s_wdata[m_gnt[c]];
            end else begin
               e_raddr = s_addr[m_gnt[c]];
            end
         end
         if (s_rstn && busy[c] && rspc[c] < 0 && n >= gcyc[c] + 2 && s_rsp[c]) rspc[c] = n;
      end
      if (s_rstn && busy[1] && rspc[1] >= 0 && n == rspc[1] + 1) cap = s_rdata;
      if (!s_rstn) model_reset();
   endtask

   task automatic step();
      @(negedge clk);
      rstn = s_rstn;
      bus.req_valid_i = s_valid;
      bus.req_we_i    = s_we;
      for (int i = 0; i < N; i++) begin
         bus.req_addr_i[i*AW +: AW]  = s_addr[i];
         bus.req_wdata_i[i*DW +: DW] = s_wdata[i];
      end
      bus.mgr_rsp_i     = s_rsp;
      bus.mgr_rd_data_i = s_rdata;
      #1;
      act_ready = bus.req_ready_o;
      act_req   = bus.mgr_req_o;
      act_wdone = bus.wr_done_o;
      act_rdone = bus.rd_done_o;
      act_rdata = bus.rd_data_o;
      act_waddr = bus.mgr_wr_addr_o;
      act_raddr = bus.mgr_rd_addr_o;
      act_wdata = bus.mgr_wdata_o;
      model_cycle();
      ncyc++;
   endtask

   // Manager behaviour; eager answers at the earliest legal cycle with no stray pulses.
   task automatic auto_mgr(input bit eager);
      for (int c = 0; c < 2; c++) begin
         if (in_wait(c)) s_rsp[c] = eager ? 1'b1 : ($urandom_range(2) == 0);
         else            s_rsp[c] = eager ? 1'b0 : ($urandom_range(7) == 0);
      end
      s_rdata = $urandom;
   endtask

   task automatic do_reset();
      s_rstn = 1'b0; s_valid = '0; s_rsp = '0;
      repeat (2) step();
      s_rstn = 1'b1;
   endtask

   task automatic drain();
      s_valid = '0;
      for (int k = 0; k < 30 && (busy[0] || busy[1]); k++) begin
         auto_mgr(1'b1);
         step();
      end
      s_rsp = '0;
   endtask

   int            gq [$];
   logic [AW-1:0] aq [$];
   int            exp_order [5] = '{0, 1, 2, 3, 0};
   logic [N-1:0]  wseen, rseen, got;
   bit            r_pend [N];
   bit            r_out  [N];

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", ncyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      s_rstn = 1'b0; s_valid = '0; s_we = '0; s_rsp = '0; s_rdata = '0;
      for (int i = 0; i < N; i++) begin s_addr[i] = '0; s_wdata[i] = '0; end
      bus.req_valid_i = '0; bus.req_we_i = '0; bus.req_addr_i = '0;
      bus.req_wdata_i = '0; bus.mgr_rsp_i = '0; bus.mgr_rd_data_i = '0;
      model_reset();

      // single write, requester 2
      do_reset();
      s_valid = 4'b0100; s_we = 4'b0100; s_addr[2] = 16'h0040; s_wdata[2] = 32'hDEADBEEF;
      step(); chk("sw_ready", 64'(act_ready), 64'h4);
      s_valid = '0;
      step(); chk("sw_req", 64'(act_req), 64'h1);
      chk("sw_addr", 64'(act_waddr), 64'h0040);
      chk("sw_data", 64'(act_wdata), 64'hDEADBEEF);
      repeat (3) step();
      s_rsp = 2'b01; step(); s_rsp = '0;
      step(); chk("sw_done", 64'(act_wdone), 64'h4);
      step(); chk("sw_done_once", 64'(act_wdone), 64'h0);

      // single read, requester 1
      s_valid = 4'b0010; s_we = '0; s_addr[1] = 16'h0010;
      step(); chk("sr_ready", 64'(act_ready), 64'h2);
      s_valid = '0;
      step(); chk("sr_req", 64'(act_req), 64'h2);
      chk("sr_addr", 64'(act_raddr), 64'h0010);
      s_rsp = 2'b10; step(); s_rsp = '0;
      s_rdata = 32'h12345678; step();
      s_rdata = 32'hA5A5A5A5; step();
      chk("sr_done", 64'(act_rdone), 64'h2);
      chk("sr_data", 64'(act_rdata), 64'h12345678);
      step(); chk("sr_hold", 64'(act_rdata), 64'h12345678);

      // round-robin fairness with all requesters writing continuously
      do_reset();
      s_valid = '1; s_we = '1;
      for (int i = 0; i < N; i++) s_addr[i] = AW'(i * 16'h0100);
      for (int k = 0; k < 40 && (gq.size() < 5 || aq.size() < 5); k++) begin
         auto_mgr(1'b1);
         step();
         for (int i = 0; i < N; i++) if (act_ready[i]) gq.push_back(i);
         if (act_req[0]) aq.push_back(act_waddr);
      end
      for (int k = 0; k < 5; k++) begin
         chk("rr_order", (k < gq.size()) ? 64'(gq[k]) : 64'hFF, 64'(exp_order[k]));
         chk("rr_addr", (k < aq.size()) ? 64'(aq[k]) : 64'hFFFF, 64'(exp_order[k] * 16'h0100));
      end
      drain();

      // concurrent write (0) and read (3)
      do_reset();
      s_valid = 4'b1001; s_we = 4'b0001; s_addr[0] = 16'h1234; s_addr[3] = 16'hBEEF;
      step(); chk("cc_ready", 64'(act_ready), 64'h9);
      s_valid = '0;
      step(); chk("cc_req", 64'(act_req), 64'h3);
      wseen = '0; rseen = '0;
      for (int k = 0; k < 10; k++) begin
         auto_mgr(1'b1);
         step();
         wseen |= act_wdone; rseen |= act_rdone;
      end
      chk("cc_wdone", 64'(wseen), 64'h1);
      chk("cc_rdone", 64'(rseen), 64'h8);

      // wrap/skip: ptr=3 with write candidates {1,3}
      do_reset();
      s_valid = 4'b0100; s_we = 4'b0100;
      step();
      drain();
      s_valid = 4'b1010; s_we = 4'b1010;
      step(); chk("wrap_first", 64'(act_ready), 64'h8);
      s_valid = 4'b0010; got = '0;
      for (int k = 0; k < 10; k++) begin
         auto_mgr(1'b1);
         step();
         if (act_ready != '0) begin got = act_ready; break; end
      end
      chk("wrap_second", 64'(got), 64'h2);
      drain();

      // reset in the middle of a write
      do_reset();
      s_valid = 4'b0100; s_we = 4'b0100;
      step();
      s_valid = '0;
      repeat (3) step();
      s_rstn = 1'b0; s_rsp = 2'b01; step();
      s_rstn = 1'b1; s_rsp = '0; step();
      chk("rst_req", 64'(act_req), 64'h0);
      chk("rst_waddr", 64'(act_waddr), 64'h0);
      chk("rst_wdata", 64'(act_wdata), 64'h0);
      chk("rst_rdata", 64'(act_rdata), 64'h0);
      for (int k = 0; k < 3; k++) begin
         step(); chk("rst_no_done", 64'(act_wdone), 64'h0);
      end
      s_valid = 4'b1001; s_we = 4'b1001;
      step(); chk("rst_ptr0", 64'(act_ready), 64'h1);
      drain();

      // randomized traffic
      do_reset();
      for (int i = 0; i < N; i++) begin r_pend[i] = 0; r_out[i] = 0; end
      repeat (3000) begin
         for (int i = 0; i < N; i++) begin
            if (!r_pend[i] && !r_out[i] && $urandom_range(3) == 0) begin
               r_pend[i]  = 1;
               s_we[i]    = 1'($urandom_range(1));
               s_addr[i]  = AW'($urandom);
               s_wdata[i] = $urandom;
            end
            s_valid[i] = r_pend[i];
         end
         s_rstn = ($urandom_range(799) != 0);
         auto_mgr(1'b0);
         step();
         for (int c = 0; c < 2; c++) begin
            if (m_done[c] >= 0) r_out[m_done[c]] = 0;
            if (m_gnt[c] >= 0) begin r_pend[m_gnt[c]] = 0; r_out[m_gnt[c]] = 1; end
         end
         if (!s_rstn) for (int i = 0; i < N; i++) begin r_pend[i] = 0; r_out[i] = 0; end
      end
      s_rstn = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
